// File: rtl/display_source_arbiter.sv
// display_source_arbiter: scan tick generation and frame-aligned selection of score, timer or message for a 4-digit display
module display_source_arbiter #(
  parameter int SCAN_DIV = 50000,
  parameter int HOLD_FRAMES = 250,
  parameter int CNT_W = 16
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [15:0] iScore,
  input  logic [15:0] iTimer,
  input  logic        iTimerEn,
  input  logic [15:0] iMsg,
  input  logic        iMsgReq,
  output logic [15:0] oData,
  output logic        oScanTick,
  output logic        oFrame,
  output logic [1:0]  oOwner,
  output logic        oMsgAck,
  output logic        oMsgBusy
);
  typedef enum logic [1:0] {SCORE = 2'd0, TIMER = 2'd1, MSG = 2'd2} state_t;
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, hold, hold_nxt;
  logic [1:0] digit;
  logic pending, ack_nxt;
  logic [15:0] msg_q, data_nxt;
  always_comb begin
    nxt = state;
    hold_nxt = hold;
    ack_nxt = 1'b0;
    data_nxt = oData;
    if (oFrame) begin
      if (state == MSG && hold != '0) begin
        hold_nxt = hold - ONE;
      end else if (pending || iMsgReq) begin
        nxt = MSG;
        hold_nxt = HOLD_M1;
        ack_nxt = 1'b1;
        data_nxt = iMsgReq ? iMsg : msg_q;
      end else begin
        nxt = iTimerEn ? TIMER : SCORE;
        data_nxt = iTimerEn ? iTimer : iScore;
      end
    end
  end
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt <= '0;
      digit <= 2'd0;
      oScanTick <= 1'b0;
      oFrame <= 1'b0;
      state <= SCORE;
      hold <= '0;
      oData <= 16'd0;
      oMsgAck <= 1'b0;
      pending <= 1'b0;
      msg_q <= 16'd0;
    end else begin
      cnt <= (cnt == DIV_M1) ? '0 : cnt + ONE;
      oScanTick <= cnt == DIV_M1;
      oFrame <= cnt == DIV_M1 && digit == 2'd3;
      digit <= digit + {1'b0, oScanTick};
      state <= nxt;
      hold <= hold_nxt;
      oData <= data_nxt;
      oMsgAck <= ack_nxt;
      pending <= ack_nxt ? 1'b0 : (pending | iMsgReq);
      if (iMsgReq) msg_q <= iMsg;
    end
  end
  assign oOwner = state;
  assign oMsgBusy = pending | (state == MSG);
endmodule

// File: tb/tb_display_source_arbiter.sv
// tb_display_source_arbiter: per-frame scoreboard plus scan-timing monitor for display_source_arbiter
module tb_display_source_arbiter;
  logic iClk, iRstN, iTimerEn, iMsgReq;
  logic [15:0] iScore, iTimer, iMsg, oData;
  logic oScanTick, oFrame, oMsgAck, oMsgBusy;
  logic [1:0] oOwner;
  typedef struct packed {logic [1:0] o; logic [15:0] d; logic a;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, cyc;
  logic prev_frame = 1'b0;

  display_source_arbiter #(.SCAN_DIV(4), .HOLD_FRAMES(2), .CNT_W(16)) dut (
    .iClk(iClk), .iRstN(iRstN), .iScore(iScore), .iTimer(iTimer), .iTimerEn(iTimerEn),
    .iMsg(iMsg), .iMsgReq(iMsgReq), .oData(oData), .oScanTick(oScanTick), .oFrame(oFrame),
    .oOwner(oOwner), .oMsgAck(oMsgAck), .oMsgBusy(oMsgBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk or negedge iRstN)
    if (!iRstN) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic wait_frame;
    int t = 0;
    do begin
      @(negedge iClk);
      t++;
    end while (!oFrame && t < 40);
    if (!oFrame) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: no oFrame within 40 cycles at %0t", $time);
      summary();
    end
  endtask

  task automatic push(input logic [1:0] o, input logic [15:0] d, input logic a);
    q.push_back({o, d, a});
  endtask

  task automatic req(input logic [15:0] m);
    iMsg = m;
    iMsgReq = 1'b1;
    idle(1);
    iMsgReq = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, oData, 16'h0);
    chk({tag, "_owner"}, 16'(oOwner), 16'h0);
    chk({tag, "_tick"}, 16'(oScanTick), 16'h0);
    chk({tag, "_frame"}, 16'(oFrame), 16'h0);
    chk({tag, "_ack"}, 16'(oMsgAck), 16'h0);
    chk({tag, "_busy"}, 16'(oMsgBusy), 16'h0);
  endtask

  always @(negedge iClk) begin
    if (!iRstN) prev_frame = 1'b0;
    else begin
      chk("scan_tick", 16'(oScanTick), 16'(cyc > 0 && cyc % 4 == 0));
      chk("frame", 16'(oFrame), 16'(cyc > 0 && cyc % 16 == 0));
      if (prev_frame) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: frame with no expectation at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("owner", 16'(oOwner), 16'(e.o));
          chk("data", oData, e.d);
          chk("ack", 16'(oMsgAck), 16'(e.a));
        end
      end else chk("ack_idle", 16'(oMsgAck), 16'h0);
      prev_frame = oFrame;
    end
  end

  initial begin
    iRstN = 1'b0; iScore = 16'h1234; iTimer = 16'h0; iTimerEn = 1'b0; iMsg = 16'h0; iMsgReq = 1'b0;
    idle(3);
    chk_zero("reset");
    iRstN = 1'b1;
    wait_frame; push(2'd0, 16'h1234, 1'b0);
    idle(6); iScore = 16'h5678; idle(1);
    chk("score_frozen", oData, 16'h1234);
    wait_frame; push(2'd0, 16'h5678, 1'b0);
    idle(3); iTimer = 16'h0059; iTimerEn = 1'b1;
    wait_frame; push(2'd1, 16'h0059, 1'b0);
    idle(5); iTimerEn = 1'b0;
    wait_frame; push(2'd0, 16'h5678, 1'b0);
    idle(2); iTimerEn = 1'b1;
    wait_frame; push(2'd1, 16'h0059, 1'b0);
    idle(4); req(16'hDEAD);
    chk("busy_on_req", 16'(oMsgBusy), 16'h1);
    chk("owner_before_frame", 16'(oOwner), 16'h1);
    wait_frame; push(2'd2, 16'hDEAD, 1'b1);
    wait_frame; push(2'd2, 16'hDEAD, 1'b0);
    idle(3); req(16'hBEEF);
    wait_frame; push(2'd2, 16'hBEEF, 1'b1);
    wait_frame; push(2'd2, 16'hBEEF, 1'b0);
    wait_frame; iMsg = 16'hCAFE; iMsgReq = 1'b1; push(2'd2, 16'hCAFE, 1'b1);
    idle(1); iMsgReq = 1'b0;
    wait_frame; push(2'd2, 16'hCAFE, 1'b0);
    wait_frame; push(2'd1, 16'h0059, 1'b0);
    idle(2);
    chk("busy_clear", 16'(oMsgBusy), 16'h0);
    idle(2); req(16'hF00D);
    wait_frame; push(2'd2, 16'hF00D, 1'b1);
    idle(3); req(16'h1111);
    chk("busy_pending", 16'(oMsgBusy), 16'h1);
    idle(2);
    #2 iRstN = 1'b0;
    #1 chk_zero("async_reset");
    iTimerEn = 1'b0;
    idle(2);
    iRstN = 1'b1;
    idle(2);
    chk("busy_after_reset", 16'(oMsgBusy), 16'h0);
    wait_frame; push(2'd0, 16'h5678, 1'b0);
    wait_frame; push(2'd0, 16'h5678, 1'b0);
    idle(2);
    chk("queue_drained", 16'(q.size()), 16'h0);
    summary();
  end
endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Schedules the shared 4-digit 7-segment display among three data sources: game score, countdown timer and one-shot messages.
- Generates the digit-scan enable tick that drives the display's scan.
- Selects which 16-bit hex word the display shows, switching only on frame boundaries (after all 4 digits are scanned) so a frame never mixes two sources.
- Sits between the game core and the display driver.

Parameters:
- SCAN_DIV, 50000, iClk cycles per digit-scan tick (must be >=2).
- HOLD_FRAMES, 250, full 4-digit frames a message stays on screen (must be >=1).
- CNT_W, 16, width of the prescaler counter and the hold counter.

Ports:
- iClk  input  1  system clock.
- iRstN  input  1  asynchronous, active-low reset.
- iScore  input  16  score word, 4 hex digits.
- iTimer  input  16  timer word, 4 hex digits.
- iTimerEn  input  1  level: timer is requesting the display.
- iMsg  input  16  message word.
- iMsgReq  input  1  single-cycle pulse: request to show iMsg.
- oData  output  16  word presented to the display driver.
- oScanTick  output  1  one-cycle pulse per digit slot.
- oFrame  output  1  one-cycle pulse, coincident with the 4th scan tick of each frame.
- oOwner  output  2  current source: 0 = score, 1 = timer, 2 = message.
- oMsgAck  output  1  one-cycle pulse when a message is accepted.
- oMsgBusy  output  1  high while a message is displayed or pending.

Behaviour:
- Reset is asynchronous and active-low. While iRstN is low, every output and register is 0: oData, oScanTick, oFrame, oOwner (SCORE), oMsgAck, oMsgBusy, prescaler, digit counter, hold counter, pending flag and message latch.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - oScanTick is registered and high for the single cycle after the count reaches SCAN_DIV-1, i.e. exactly one pulse every SCAN_DIV cycles.
  - The first pulse comes SCAN_DIV cycles after reset release.
- Digit counter:
  - 2-bit, advances on each scan tick.
  - oFrame is asserted together with the scan tick that wraps the counter from 3 to 0.
  - Frame period is 4*SCAN_DIV cycles.
- Message request:
  - iMsgReq sets the pending flag and latches iMsg into a message register in the same edge.
  - A later request overwrites the latch (last writer wins); only one pending message is held.
- FSM states: SCORE, TIMER, MSG. Transitions are evaluated only on oFrame cycles.
- On oFrame, next state is chosen in strict priority order:
  1. If in MSG and the hold counter has not expired: stay in MSG.
  2. Else if pending (including an iMsgReq arriving in this same cycle): go to MSG. Load the hold counter with HOLD_FRAMES-1, clear pending, pulse oMsgAck for one cycle, and take oData from the message latch (or from iMsg directly when the request is same-cycle).
  3. Else if iTimerEn is high: go to TIMER.
  4. Else: go to SCORE.
- In MSG, the hold counter decrements once per oFrame. It expires at 0, so the message is displayed for exactly HOLD_FRAMES frames.
- oData update rules:
  - Updates only on oFrame cycles, using the source of the next state.
  - SCORE and TIMER snapshot the live iScore/iTimer at each frame boundary; the value is frozen between boundaries to prevent tearing.
  - MSG holds the latched message constant for the whole hold period.
- oOwner is registered and changes on the same edge as oData.
- oMsgBusy = pending OR (state == MSG).
- Boundary cases:
  - A request arriving during MSG is queued, not preemptive. When the hold expires, the FSM re-enters MSG with the new word and issues a new oMsgAck.
  - A message can never be dropped while pending.
  - iTimerEn deasserting mid-frame takes effect at the next boundary.
  - Reset asserted mid-message clears the pending flag and message latch; no oMsgAck is issued afterwards.

Test Plan:
- Setup for all scenarios: SCAN_DIV=4, HOLD_FRAMES=2.
- Reset, iScore=16'h1234, no requests -> oScanTick every 4 cycles from cycle 4; oFrame every 16 cycles; after the first frame oData=16'h1234, oOwner=0.
- Change iScore to 16'h5678 mid-frame -> oData stays 16'h1234 until the next oFrame, then becomes 16'h5678 on that edge.
- iTimerEn=1, iTimer=16'h0059 -> at the next frame oOwner=1, oData=16'h0059. Drop iTimerEn -> back to oOwner=0 at the following frame.
- iMsgReq pulse with iMsg=16'hDEAD while timer is active -> oMsgBusy=1 immediately. At the next frame: oMsgAck single pulse, oOwner=2, oData=16'hDEAD for exactly 2 frames, then oOwner=1.
- iMsgReq(16'hBEEF) during an active 16'hDEAD hold -> DEAD completes its 2 frames, then a second oMsgAck and BEEF is shown for 2 frames. iMsgReq coincident with oFrame is accepted on that same frame.
- Assert iRstN low mid-message with a pending request -> all outputs 0 immediately (asynchronous). After release: oOwner=0, no oMsgAck, first oScanTick 4 cycles later.
